alu_operand_entry: RTL and testbench

- Sequential front end of the 4-bit ALU lab: turns a bouncy, active-low pushbutton and slide switches into stable operands A, B and the operation select sum_notsub.
- It feeds the add/sub datapath and 7-segment display chain; it is the input end of that datapath, where the display chain is the output end.
- The operator enters values in order: press to load A, press to load B plus the operation, press to start over.

---
 rtl/alu_operand_entry.sv | 170 +++++++++++++++++
 tb/tb_alu_operand_entry.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_entry.sv
// ---------------------------------------------------------------------------
// alu_operand_entry
//
// Input front end of the 4-bit ALU lab. A bouncy active-low pushbutton is
// synchronized, debounced and edge-detected into a single-cycle press pulse.
// Each press steps an operand-entry sequence that latches A, then B together
// with the operation select, then clears valid so a new entry can begin.
//
// Ports:
//   clk         in   1  system clock, all state updates on rising edge
//   rst         in   1  synchronous active-high reset
//   key_n       in   1  raw pushbutton, active-low, asynchronous, bouncy
//   sw          in   4  operand value from slide switches (quasi-static)
//   op_sw       in   1  operation switch: 1 = add, 0 = subtract
//   A           out  4  latched operand A
//   B           out  4  latched operand B
//   sum_notsub  out  1  latched operation select
//   valid       out  1  high when A, B and operation are all loaded
//   stage       out  2  current state encoding, for LEDs
//
// FSM states:
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_LOAD_A   | waiting for the press that latches A from sw
//   ST_LOAD_B   | waiting for the press that latches B and op_sw
//   ST_RUN      | operands valid; next press clears valid and restarts
//   ST_ILLEGAL  | unreachable encoding; recovers to ST_LOAD_A
// ---------------------------------------------------------------------------
module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic [3:0] sw,
    input  logic       op_sw,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       sum_notsub,
    output logic       valid,
    output logic [1:0] stage
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'b00,
        ST_LOAD_B  = 2'b01,
        ST_RUN     = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizer, debouncer and press detect
    // -----------------------------------------------------------------------
    logic             s1_q;
    logic             s2_q;
    logic             key_db_q;
    logic             key_db_d;
    logic             key_db_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press;

    // The count only advances while the synchronized key disagrees with the
    // debounced level; any return to agreement restarts it from zero.
    always_comb begin
        key_db_d = key_db_q;
        cnt_d    = cnt_q;
        if (s2_q == key_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            key_db_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            key_db_q     <= 1'b1;
            key_db_dly_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            s1_q         <= key_n;
            s2_q         <= s1_q;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
            cnt_q        <= cnt_d;
        end
    end

    // Falling debounced level only; release does not pulse.
    assign press = key_db_dly_q & ~key_db_q;

    // -----------------------------------------------------------------------
    // Operand-entry FSM
    // -----------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [3:0] a_q;
    logic [3:0] a_d;
    logic [3:0] b_q;
    logic [3:0] b_d;
    logic       sum_q;
    logic       sum_d;
    logic       valid_q;
    logic       valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        case (state_q)
            ST_LOAD_A: begin
                if (press) begin
                    a_d     = sw;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (press) begin
                    b_d     = sw;
                    sum_d   = op_sw;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (press) begin
                    valid_d = 1'b0;
                    state_d = ST_LOAD_A;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            sum_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign sum_notsub = sum_q;
    assign valid      = valid_q;
    assign stage      = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
module tb_alu_operand_entry;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic [3:0] sw;
    logic       op_sw;
    logic [3:0] A;
    logic [3:0] B;
    logic       sum_notsub;
    logic       valid;
    logic [1:0] stage;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int press_cyc = 0;
    bit lat_arm = 1'b0;

    logic [11:0] exp_q[$];
    logic [11:0] prev_obs;
    logic [11:0] obs;
    logic [11:0] e;

    // reference model of the entry sequence
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic       m_s;
    logic       m_v;
    logic [1:0] m_st;

    alu_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sw         (sw),
        .op_sw      (op_sw),
        .A          (A),
        .B          (B),
        .sum_notsub (sum_notsub),
        .valid      (valid),
        .stage      (stage)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_a = 4'd0; m_b = 4'd0; m_s = 1'b1; m_v = 1'b0; m_st = 2'b00;
    endtask

    task automatic model_press(input logic [3:0] s, input logic o);
        case (m_st)
            2'b00: begin m_a = s; m_st = 2'b01; end
            2'b01: begin m_b = s; m_s = o; m_v = 1'b1; m_st = 2'b10; end
            default: begin m_v = 1'b0; m_st = 2'b00; end
        endcase
        exp_q.push_back({m_a, m_b, m_s, m_v, m_st});
    endtask

    task automatic press(input logic [3:0] s, input logic o, input int n_low, input int n_high);
        sw = s; op_sw = o;
        model_press(s, o);
        key_n = 1'b0;
        press_cyc = cyc;
        lat_arm = 1'b1;
        repeat (n_low) @(posedge clk);
        #1 key_n = 1'b1;
        repeat (n_high) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_A"}, A, m_a);
        chk({tag, "_B"}, B, m_b);
        chk({tag, "_s"}, sum_notsub, m_s);
        chk({tag, "_v"}, valid, m_v);
        chk({tag, "_st"}, stage, m_st);
    endtask

    // Output monitor: every output change must match the next expected entry.
    always @(negedge clk) begin
        obs = {A, B, sum_notsub, valid, stage};
        if (rst) begin
            prev_obs = obs;
        end else if (obs !== prev_obs) begin
            if (exp_q.size() == 0) begin
                chk("unexp_change", obs, prev_obs);
            end else begin
                e = exp_q.pop_front();
                chk("out", obs, e);
            end
            if (lat_arm) begin
                chk("latency", cyc - press_cyc, LAT);
                lat_arm = 1'b0;
            end
            prev_obs = obs;
        end
    end

    initial begin
        logic [8:0] bounce;
        rst = 1'b1; key_n = 1'b1; sw = 4'd0; op_sw = 1'b1;
        model_reset();

        // 1. reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_model("rst");
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_model("idle");

        // 2. load A, latency checked by monitor
        press(4'h5, 1'b1, 10, 10);
        check_model("loadA");
        press(4'h2, 1'b1, 10, 10);
        press(4'h0, 1'b1, 10, 10);
        check_model("cycle1");

        // 3. full sequence
        press(4'h3, 1'b1, 10, 10);
        press(4'h6, 1'b0, 10, 10);
        check_model("run");
        press(4'h1, 1'b1, 10, 10);
        check_model("restart");

        // 4. bounce rejection, then a clean press
        sw = 4'hA; op_sw = 1'b1;
        bounce = 9'b100010010; // bit i = key_n on edge i: 0,1,0,0,1,0,0,0,1
        for (int i = 0; i < 9; i++) begin
            key_n = bounce[i];
            @(posedge clk);
            #1;
        end
        key_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_model("bounce");
        press(4'hA, 1'b1, 10, 10);
        check_model("post_bounce");

        // 5. long hold with switch changes after the load edge
        sw = 4'hC; op_sw = 1'b1;
        model_press(4'hC, 1'b1);
        key_n = 1'b0;
        press_cyc = cyc;
        lat_arm = 1'b1;
        repeat (15) @(posedge clk);
        #1 sw = 4'hF; op_sw = 1'b0;
        repeat (35) @(posedge clk);
        #1 key_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_model("hold");

        press(4'h4, 1'b1, 10, 10);
        press(4'h9, 1'b1, 10, 10);
        check_model("pre_rst");

        // 6. reset mid-entry while key low and mid-count
        sw = 4'h7; op_sw = 1'b1;
        key_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check_model("midrst");
        #1 rst = 1'b0;
        model_press(4'h7, 1'b1);
        press_cyc = cyc;
        lat_arm = 1'b1;
        repeat (12) @(posedge clk);
        #1 key_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_model("reload");

        chk("sb_left", exp_q.size(), 0);
        chk("lat_pending", {31'd0, lat_arm}, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
